// File: rtl/egm_hw_responder.sv
`default_nettype none
// ============================================================================
// Module  : egm_hw_responder
// Brief   : Hardware far-end responder for the EGM stimulus/response link.
//           Answers each accepted stimulus rising edge with a RESP_WIDTH-clock
//           response pulse after a programmable delay; counts handled/missed.
//           Optional rise-to-rise period statistics under macro EGM_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module egm_hw_responder #(
    parameter int RESP_WIDTH = 4,
    parameter int CNT_W      = 16,
    parameter int PER_W      = 24
) (
    input  logic             clkin_50,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stimulus,
    input  logic [15:0]      resp_delay,
    input  logic             clear_counts,
    output logic             response,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_count,
    output logic [CNT_W-1:0] miss_count
`ifdef EGM_STATS_EN
    ,
    output logic [PER_W-1:0] stim_period,
    output logic [PER_W-1:0] stim_period_max,
    output logic             period_valid
`endif
);

    localparam int c_pw_w = (RESP_WIDTH > 1) ? $clog2(RESP_WIDTH) : 1;
    localparam logic [c_pw_w-1:0] c_pw_last = c_pw_w'(RESP_WIDTH - 1);

    generate
        if (RESP_WIDTH < 1 || CNT_W < 1 || PER_W < 1) begin : g_param_check
            $error("egm_hw_responder: RESP_WIDTH, CNT_W and PER_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_s1, r_s2, r_s3;
    logic [15:0]       r_wait_cnt;
    logic [c_pw_w-1:0] r_pulse_cnt;
    logic              w_rise;
    logic              w_accept;
    logic              w_miss;

    // Synchronisers reset high so a stimulus held high through reset is no edge
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= stimulus;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise   = r_s2 & ~r_s3;
    assign w_accept = w_rise & enable & (r_state == ST_IDLE);
    assign w_miss   = w_rise & ~w_accept;

    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            response    <= 1'b0;
            busy        <= 1'b0;
            r_wait_cnt  <= 16'd0;
            r_pulse_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        busy <= 1'b1;
                        if (resp_delay == 16'd0) begin
                            r_state     <= ST_PULSE;
                            response    <= 1'b1;
                            r_pulse_cnt <= c_pw_last;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= resp_delay - 16'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_wait_cnt == 16'd0) begin
                        r_state     <= ST_PULSE;
                        response    <= 1'b1;
                        r_pulse_cnt <= c_pw_last;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 16'd1;
                    end
                end
                ST_PULSE: begin
                    if (!enable || r_pulse_cnt == '0) begin
                        r_state  <= ST_IDLE;
                        response <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - c_pw_w'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    response <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters; a clear beats any increment in the same cycle
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            pulse_count <= '0;
            miss_count  <= '0;
        end else if (clear_counts) begin
            pulse_count <= '0;
            miss_count  <= '0;
        end else begin
            if (w_accept && pulse_count != '1) begin
                pulse_count <= pulse_count + CNT_W'(1);
            end
            if (w_miss && miss_count != '1) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

`ifdef EGM_STATS_EN
    logic [PER_W-1:0] r_per_cnt;
    logic             r_seen_rise;

    // Interval counter restarts at 1 on every rise, so at the next rise it holds the distance
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt       <= '0;
            r_seen_rise     <= 1'b0;
            stim_period     <= '0;
            stim_period_max <= '0;
            period_valid    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_rise) begin
                r_per_cnt <= PER_W'(1);
            end else if (r_per_cnt != '1) begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
            end
            if (clear_counts) begin
                r_seen_rise     <= 1'b0;
                stim_period     <= '0;
                stim_period_max <= '0;
            end else if (w_rise) begin
                r_seen_rise <= 1'b1;
                if (r_seen_rise) begin
                    stim_period  <= r_per_cnt;
                    period_valid <= 1'b1;
                    if (r_per_cnt > stim_period_max) begin
                        stim_period_max <= r_per_cnt;
                    end
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_egm_hw_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_egm_hw_responder
// Brief   : Self-checking bench for egm_hw_responder: directed scenarios plus
//           random stimulus against a cycle-timeline reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_egm_hw_responder;

    localparam int RW      = 4;
    localparam int CW      = 5;
    localparam int PW      = 24;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int HIST    = 8192;

    logic          clkin_50 = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          stimulus;
    logic [15:0]   resp_delay;
    logic          clear_counts;
    logic          response;
    logic          busy;
    logic [CW-1:0] pulse_count;
    logic [CW-1:0] miss_count;
`ifdef EGM_STATS_EN
    logic [PW-1:0] stim_period;
    logic [PW-1:0] stim_period_max;
    logic          period_valid;
`endif

    egm_hw_responder #(
        .RESP_WIDTH (RW),
        .CNT_W      (CW),
        .PER_W      (PW)
    ) dut (
        .clkin_50        (clkin_50),
        .rst_n           (rst_n),
        .enable          (enable),
        .stimulus        (stimulus),
        .resp_delay      (resp_delay),
        .clear_counts    (clear_counts),
        .response        (response),
        .busy            (busy),
        .pulse_count     (pulse_count),
        .miss_count      (miss_count)
`ifdef EGM_STATS_EN
        ,
        .stim_period     (stim_period),
        .stim_period_max (stim_period_max),
        .period_valid    (period_valid)
`endif
    );

    always #10 clkin_50 = ~clkin_50;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = -1;
    logic stim_h [0:HIST-1];

    // Reference model: an operation is a window of cycles, not a state machine
    int   m_acc   = -100;
    int   m_start = -100;
    int   m_end   = -100;
    int   m_pc    = 0;
    int   m_mc    = 0;
    int   m_last  = 0;
    bit   m_seen  = 1'b0;
    int   m_per   = 0;
    int   m_max   = 0;
    bit   m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic stim_at(input int i);
        if (i < 0) return 1'b1;
        return stim_h[i];
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // One clock: drive this cycle's inputs, check outputs, then advance the model
    task automatic step(input logic st, input logic en, input logic clr, input logic [15:0] dly);
        logic rise;
        logic bsy;
        @(posedge clkin_50);
        cyc++;
        #1;
        stimulus     = st;
        enable       = en;
        clear_counts = clr;
        resp_delay   = dly;
        if (cyc < HIST) stim_h[cyc] = st;
        @(negedge clkin_50);
        bsy = (cyc > m_acc) && (cyc <= m_end);
        check("response", {31'd0, response}, {31'd0, (cyc >= m_start) && (cyc <= m_end)});
        check("busy", {31'd0, busy}, {31'd0, bsy});
        check("pulse_count", 32'(pulse_count), 32'(m_pc));
        check("miss_count", 32'(miss_count), 32'(m_mc));
`ifdef EGM_STATS_EN
        check("period_valid", {31'd0, period_valid}, {31'd0, m_valid});
        check("stim_period", 32'(stim_period), 32'(m_per));
        check("stim_period_max", 32'(stim_period_max), 32'(m_max));
`endif
        // The synchroniser shows a pin edge two cycles after the pin is sampled
        rise    = stim_at(cyc - 2) & ~stim_at(cyc - 3);
        m_valid = 1'b0;
        if (rise) begin
            if (en && !bsy) begin
                m_acc   = cyc;
                m_start = cyc + 1 + int'(dly);
                m_end   = cyc + int'(dly) + RW;
                m_pc    = sat(m_pc + 1);
            end else begin
                m_mc = sat(m_mc + 1);
            end
        end
        if (!en && bsy) m_end = cyc;
        if (clr) begin
            m_pc   = 0;
            m_mc   = 0;
            m_per  = 0;
            m_max  = 0;
            m_seen = 1'b0;
        end else if (rise) begin
            if (m_seen) begin
                m_per   = cyc - m_last;
                m_valid = 1'b1;
                if (m_per > m_max) m_max = m_per;
            end
            m_seen = 1'b1;
        end
        if (rise) m_last = cyc;
    endtask

    task automatic hold(input int n, input logic st, input logic en, input logic clr,
                        input logic [15:0] dly);
        for (int i = 0; i < n; i++) step(st, en, clr, dly);
    endtask

    initial begin
        logic        st;
        logic        en;
        logic [15:0] dly;
        int          len;

        rst_n        = 1'b0;
        stimulus     = 1'b1;
        enable       = 1'b0;
        clear_counts = 1'b0;
        resp_delay   = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkin_50);
            check("reset_response", {31'd0, response}, 32'd0);
            check("reset_busy", {31'd0, busy}, 32'd0);
            check("reset_pulse_count", 32'(pulse_count), 32'd0);
            check("reset_miss_count", 32'(miss_count), 32'd0);
        end
        rst_n = 1'b1;

        // Stimulus high through reset is not an edge
        hold(100, 1'b1, 1'b1, 1'b0, 16'd10);
        check("no_edge_pulse_count", 32'(pulse_count), 32'd0);

        // Delay 10
        hold(5, 1'b0, 1'b1, 1'b0, 16'd10);
        hold(30, 1'b1, 1'b1, 1'b0, 16'd10);
        check("delay10_pulse_count", 32'(pulse_count), 32'd1);
        hold(5, 1'b0, 1'b1, 1'b0, 16'd0);

        // Delay 0: rise in last pulse cycle is a miss
        hold(1, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(3, 1'b0, 1'b1, 1'b0, 16'd0);
        hold(10, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(10, 1'b0, 1'b1, 1'b0, 16'd0);
        check("back2back_miss", 32'(miss_count), 32'd1);

        // Delay 0: rise in first idle cycle is accepted
        hold(1, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(4, 1'b0, 1'b1, 1'b0, 16'd0);
        hold(10, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(10, 1'b0, 1'b1, 1'b0, 16'd0);
        check("first_idle_accept", 32'(pulse_count), 32'd4);

        // Abort: enable drops 20 cycles into a 50-cycle wait
        hold(22, 1'b1, 1'b1, 1'b0, 16'd50);
        hold(60, 1'b1, 1'b0, 1'b0, 16'd50);
        hold(5, 1'b0, 1'b0, 1'b0, 16'd50);
        hold(10, 1'b1, 1'b0, 1'b0, 16'd50);
        check("disabled_miss", 32'(miss_count), 32'd2);
        hold(5, 1'b0, 1'b1, 1'b0, 16'd0);

        // Saturation of both counters, then clear on a rise cycle
        for (int k = 0; k < CNT_MAX + 4; k++) begin
            hold(3, 1'b1, 1'b1, 1'b0, 16'd0);
            hold(5, 1'b0, 1'b1, 1'b0, 16'd0);
        end
        check("pulse_saturated", 32'(pulse_count), 32'(CNT_MAX));
        for (int k = 0; k < CNT_MAX + 4; k++) begin
            hold(2, 1'b1, 1'b0, 1'b0, 16'd0);
            hold(2, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        check("miss_saturated", 32'(miss_count), 32'(CNT_MAX));
        hold(2, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(1, 1'b1, 1'b1, 1'b1, 16'd0);
        hold(1, 1'b1, 1'b1, 1'b0, 16'd0);
        check("clear_on_rise", 32'(pulse_count), 32'd0);
        hold(8, 1'b0, 1'b1, 1'b0, 16'd0);

        // Random stimulus
        st = 1'b0;
        for (int seg = 0; seg < 350; seg++) begin
            len = int'($urandom_range(1, 12));
            st  = ~st;
            en  = ($urandom_range(0, 9) != 0);
            dly = 16'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) begin
                step(st, en, ($urandom_range(0, 99) == 0), dly);
            end
        end
        hold(30, 1'b0, 1'b1, 1'b0, 16'd0);

`ifdef EGM_STATS_EN
        // Rises 1000 then 400 clocks apart
        hold(1, 1'b0, 1'b1, 1'b1, 16'd0);
        hold(5, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(995, 1'b0, 1'b1, 1'b0, 16'd0);
        hold(5, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(395, 1'b0, 1'b1, 1'b0, 16'd0);
        hold(5, 1'b1, 1'b1, 1'b0, 16'd0);
        hold(10, 1'b0, 1'b1, 1'b0, 16'd0);
        check("stats_period", 32'(stim_period), 32'd400);
        check("stats_max", 32'(stim_period_max), 32'd1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
